// File: rtl/rv32i_wb_decoder_if.sv
// Wishbone bus bundle for rv32i_wb_decoder: the upstream master side (m_*)
// and the fan-out slave side (s_*), seen from the decoder as modport slave.
interface rv32i_wb_decoder_if #(
  parameter int NSLAVES    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                          m_cyc_i;
  logic                          m_stb_i;
  logic                          m_we_i;
  logic [DATA_WIDTH/8-1:0]       m_sel_i;
  logic [ADDR_WIDTH-1:0]         m_adr_i;
  logic [DATA_WIDTH-1:0]         m_dat_i;
  logic [DATA_WIDTH-1:0]         m_dat_o;
  logic                          m_ack_o;
  logic                          m_err_o;
  logic                          m_stall_o;
  logic [NSLAVES-1:0]            s_cyc_o;
  logic [NSLAVES-1:0]            s_stb_o;
  logic                          s_we_o;
  logic [DATA_WIDTH/8-1:0]       s_sel_o;
  logic [ADDR_WIDTH-1:0]         s_adr_o;
  logic [DATA_WIDTH-1:0]         s_dat_o;
  logic [NSLAVES*DATA_WIDTH-1:0] s_dat_i;
  logic [NSLAVES-1:0]            s_ack_i;
  logic [NSLAVES-1:0]            s_err_i;
  logic [NSLAVES-1:0]            s_stall_i;

  // Handshake: a request is taken on a rising edge with m_cyc_i && m_stb_i && !m_stall_o;
  // a slave takes its strobe on an edge with s_stb_o[i] && !s_stall_i[i]; ack/err are
  // single-cycle completions that count only while the matching cycle is open.
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o,
    output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    input  s_dat_i, s_ack_i, s_err_i, s_stall_i
  );

  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, m_stall_o,
    input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
    output s_dat_i, s_ack_i, s_err_i, s_stall_i
  );
endinterface

// File: rtl/rv32i_wb_decoder.sv
// Single-master Wishbone address decoder / response router, one access outstanding.
// Optional slave watchdog enabled by defining RV32I_WB_DEC_TIMEOUT_EN.
module rv32i_wb_decoder #(
  parameter int NSLAVES    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  rv32i_wb_decoder_if.slave bus,
  output logic [1:0] state_o
`ifdef RV32I_WB_DEC_TIMEOUT_EN
  ,
  output logic       timeout_o
`endif
);
  localparam int IDX_W = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  if (NSLAVES < 1 || NSLAVES > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("rv32i_wb_decoder: parameter out of range");
  end

  logic [1:0]            state_q;
  logic [IDX_W-1:0]      sel_q;
  logic                  we_q;
  logic [BE_W-1:0]       be_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] wdat_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  ack_q;
  logic                  err_q;

  // Lowest index wins: scan downwards so the last assignment is the smallest match.
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((bus.m_adr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  logic [NSLAVES-1:0]    sel_oh;
  logic                  sel_ack;
  logic                  sel_err;
  logic                  sel_stall;
  logic [DATA_WIDTH-1:0] sel_dat;
  logic                  active;
  logic                  expired;

  assign sel_oh    = NSLAVES'(1) << sel_q;
  assign sel_ack   = bus.s_ack_i[sel_q];
  assign sel_err   = bus.s_err_i[sel_q];
  assign sel_stall = bus.s_stall_i[sel_q];
  assign sel_dat   = bus.s_dat_i[sel_q*DATA_WIDTH +: DATA_WIDTH];
  assign active    = (state_q == REQ) || (state_q == WAIT);

`ifdef RV32I_WB_DEC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;

  assign expired   = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (active) begin
      cnt_q <= cnt_q + 1'b1;
      // Sticky flag mirrors the watchdog branch of the main FSM below.
      if (bus.m_cyc_i && !sel_ack && !sel_err && expired) timeout_q <= 1'b1;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.m_cyc_i && bus.m_stb_i) begin
            we_q   <= bus.m_we_i;
            be_q   <= bus.m_sel_i;
            adr_q  <= bus.m_adr_i;
            wdat_q <= bus.m_dat_i;
            sel_q  <= hit_idx;
            if (hit) begin
              state_q <= REQ;
            end else begin
              state_q <= RESP;
              err_q   <= 1'b1;
            end
          end
        end
        REQ, WAIT: begin
          if (!bus.m_cyc_i) begin
            state_q <= IDLE;
          end else if (sel_ack || sel_err) begin
            state_q <= RESP;
            err_q   <= sel_err;
            ack_q   <= !sel_err;
            if (sel_ack && !sel_err && !we_q) rdata_q <= sel_dat;
          end else if (expired) begin
            state_q <= RESP;
            err_q   <= 1'b1;
          end else if (state_q == REQ && !sel_stall) begin
            state_q <= WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o       = state_q;
  assign bus.m_dat_o   = rdata_q;
  assign bus.m_ack_o   = ack_q;
  assign bus.m_err_o   = err_q;
  assign bus.m_stall_o = (state_q != IDLE);
  assign bus.s_cyc_o   = active ? sel_oh : '0;
  assign bus.s_stb_o   = (state_q == REQ) ? sel_oh : '0;
  assign bus.s_we_o    = we_q;
  assign bus.s_sel_o   = be_q;
  assign bus.s_adr_o   = adr_q;
  assign bus.s_dat_o   = wdat_q;
endmodule

// File: tb/tb_rv32i_wb_decoder.sv
// Randomized scoreboard bench for rv32i_wb_decoder with reactive slave models.
`timescale 1ns/1ps
module tb_rv32i_wb_decoder;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef RV32I_WB_DEC_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif
  localparam logic [NS*AW-1:0] BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [NS*AW-1:0] MASK = {4{32'hF000_0000}};

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  always #5 clk = ~clk;

  rv32i_wb_decoder_if #(.NSLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef RV32I_WB_DEC_TIMEOUT_EN
  logic timeout;
`endif

  rv32i_wb_decoder #(
    .NSLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus),
    .state_o(state)
`ifdef RV32I_WB_DEC_TIMEOUT_EN
    ,
    .timeout_o(timeout)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic          ack;
    logic          err;
    logic [DW-1:0] dat;
    int            lat;
    int            stb_cnt;
    logic [NS-1:0] stb_mask;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdat;
    logic [BW-1:0] be;
    logic          we;
  } exp_t;

  exp_t          exp_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] model_dat = '0;

  int            cfg_stall[NS];
  int            cfg_delay[NS];
  int            cfg_kind[NS];   // 0 ack, 1 err, 2 ack+err, 3 silent
  logic [DW-1:0] cfg_rdata[NS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & MASK[i*AW +: AW]) == (BASE[i*AW +: AW] & MASK[i*AW +: AW])) return i;
    return -1;
  endfunction

  // ---------------- slave models ----------------
  initial begin : slaves
    int   scnt[NS];
    int   pend[NS];
    logic a, er, st;
    bus.s_ack_i   = '0;
    bus.s_err_i   = '0;
    bus.s_stall_i = '0;
    bus.s_dat_i   = '0;
    for (int i = 0; i < NS; i++) begin
      scnt[i] = 0;
      pend[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        a = 1'b0; er = 1'b0; st = 1'b0;
        bus.s_dat_i[i*DW +: DW] = $urandom;
        if (pend[i] == 1) begin
          a  = (cfg_kind[i] != 1);
          er = (cfg_kind[i] != 0);
          bus.s_dat_i[i*DW +: DW] = cfg_rdata[i];
          pend[i] = 0;
        end else if (pend[i] > 1) begin
          pend[i]--;
        end
        if (bus.s_stb_o[i]) begin
          if (scnt[i] < cfg_stall[i]) begin
            st = 1'b1;
            scnt[i]++;
          end else begin
            scnt[i] = 0;
            if (cfg_kind[i] != 3) pend[i] = cfg_delay[i] + 1;
          end
        end else if (!bus.s_cyc_o[i] && pend[i] == 0 && !a && !er) begin
          a  = 1'($urandom_range(0, 1));
          er = 1'($urandom_range(0, 1));
          st = 1'($urandom_range(0, 1));
        end
        bus.s_ack_i[i]   = a;
        bus.s_err_i[i]   = er;
        bus.s_stall_i[i] = st;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    int            neg;
    int            acc_neg;
    int            stb_cnt;
    logic [NS-1:0] stb_mask;
    logic [NS-1:0] cyc_mask;
    exp_t          e;
    neg = 0; acc_neg = 0; stb_cnt = 0; stb_mask = '0; cyc_mask = '0;
    forever begin
      @(negedge clk);
      #2;
      neg++;
      if (!rst) begin
        cyc_mask |= bus.s_cyc_o;
        if (|bus.s_stb_o) begin
          stb_cnt++;
          stb_mask |= bus.s_stb_o;
          if (exp_q.size() > 0) begin
            check("stb_adr_stable", bus.s_adr_o, exp_q[0].adr);
            check("stb_dat_stable", bus.s_dat_o, exp_q[0].wdat);
            check("stb_sel_stable", bus.s_sel_o, exp_q[0].be);
          end
        end
        if (bus.m_ack_o || bus.m_err_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_resp", {bus.m_ack_o, bus.m_err_o}, 2'b00);
          end else begin
            e = exp_q.pop_front();
            check("ack", bus.m_ack_o, e.ack);
            check("err", bus.m_err_o, e.err);
            check("rdata", bus.m_dat_o, e.dat);
            check("latency", 64'(neg - acc_neg - 1), 64'(e.lat));
            check("stb_cycles", 64'(stb_cnt), 64'(e.stb_cnt));
            check("stb_mask", stb_mask, e.stb_mask);
            check("cyc_mask", cyc_mask, e.stb_mask);
            check("resp_cyc_low", bus.s_cyc_o, '0);
            check("resp_stall", bus.m_stall_o, 1'b1);
            check("s_adr", bus.s_adr_o, e.adr);
            check("s_we", bus.s_we_o, e.we);
          end
        end
        if (bus.m_cyc_i && bus.m_stb_i && !bus.m_stall_o) begin
          acc_neg  = neg;
          stb_cnt  = 0;
          stb_mask = '0;
          cyc_mask = '0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [AW-1:0] a, input logic we, input logic [BW-1:0] be,
                       input logic [DW-1:0] wd);
    int budget;
    bus.m_cyc_i = 1'b1;
    bus.m_stb_i = 1'b1;
    bus.m_adr_i = a;
    bus.m_we_i  = we;
    bus.m_sel_i = be;
    bus.m_dat_i = wd;
    budget = 0;
    while (bus.m_stall_o && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (bus.m_stall_o) check("accept_timeout", 1'b1, 1'b0);
    @(posedge clk);
    #1 bus.m_stb_i = 1'b0;
  endtask

  task automatic xact(input logic [AW-1:0] a, input logic we, input logic [BW-1:0] be,
                      input logic [DW-1:0] wd, input int stall, input int delay,
                      input int kind, input logic [DW-1:0] rd);
    exp_t e;
    int   s;
    int   budget;
    s = decode(a);
    e.adr = a; e.we = we; e.be = be; e.wdat = wd;
    if (s < 0) begin
      e.ack = 1'b0; e.err = 1'b1; e.lat = 0; e.stb_cnt = 0; e.stb_mask = '0;
    end else begin
      cfg_stall[s] = stall; cfg_delay[s] = delay; cfg_kind[s] = kind; cfg_rdata[s] = rd;
      e.stb_mask = NS'(1) << s;
      e.stb_cnt  = stall + 1;
      if (kind == 3) begin
        e.ack = 1'b0; e.err = 1'b1; e.lat = TO + 1;
      end else begin
        e.ack = (kind == 0);
        e.err = (kind != 0);
        e.lat = stall + delay + 2;
        if (kind == 0 && !we) model_dat = rd;
      end
    end
    e.dat = model_dat;
    exp_q.push_back(e);
    issue(a, we, be, wd);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(bus.m_ack_o || bus.m_err_o) && budget < TO + 20);
    if (!(bus.m_ack_o || bus.m_err_o)) check("resp_timeout", 1'b0, 1'b1);
    bus.m_cyc_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    logic [AW-1:0] a;
    int            budget;
    rst = 1'b1;
    bus.m_cyc_i = 1'b0; bus.m_stb_i = 1'b0; bus.m_we_i = 1'b0;
    bus.m_sel_i = '0; bus.m_adr_i = '0; bus.m_dat_i = '0;
    for (int i = 0; i < NS; i++) begin
      cfg_stall[i] = 0; cfg_delay[i] = 0; cfg_kind[i] = 0; cfg_rdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_state", state, 2'd0);
    check("rst_ack", bus.m_ack_o, 1'b0);
    check("rst_err", bus.m_err_o, 1'b0);
    check("rst_stall", bus.m_stall_o, 1'b0);
    check("rst_dat", bus.m_dat_o, '0);
    check("rst_cyc", bus.s_cyc_o, '0);
    check("rst_adr", bus.s_adr_o, '0);
`ifdef RV32I_WB_DEC_TIMEOUT_EN
    check("rst_timeout", timeout, 1'b0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    xact(32'h1000_0040, 1'b0, 4'hF,    32'h0,         0, 0, 0, 32'hDEAD_BEEF);
    xact(32'h2000_0000, 1'b1, 4'b0011, 32'h1234_5678, 3, 0, 0, 32'hFFFF_0000);
    xact(32'h5000_0000, 1'b0, 4'hF,    32'h0,         0, 0, 0, 32'h0);
    xact(32'h3000_0010, 1'b0, 4'hF,    32'h0,         0, 0, 2, 32'hCAFE_F00D);

    // abort in WAIT; slave 0 acks two cycles later and must be ignored
    cfg_stall[0] = 0; cfg_delay[0] = 2; cfg_kind[0] = 0; cfg_rdata[0] = 32'h0BAD_0BAD;
    issue(32'h0000_0200, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    @(negedge clk);
    bus.m_cyc_i = 1'b0;
    @(negedge clk);
    check("abort_cyc", bus.s_cyc_o, '0);
    check("abort_idle", bus.m_stall_o, 1'b0);
    repeat (4) @(negedge clk);
    xact(32'h1000_0004, 1'b0, 4'hF, 32'h0, 1, 1, 0, 32'h5555_AAAA);

    // randomized traffic, back-to-back
    for (int n = 0; n < 40; n++) begin
      a = {4'($urandom_range(0, 6)), 28'($urandom)};
      xact(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
           $urandom_range(0, 3), $urandom_range(0, 2),
           ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 2), $urandom);
    end
    xact(32'h0000_0008, 1'b0, 4'hF, 32'h0, 0, 0, 0, 32'h7777_1111);

    // reset pulsed while waiting on a silent slave
    cfg_stall[1] = 0; cfg_delay[1] = 0; cfg_kind[1] = 3;
    issue(32'h1000_0100, 1'b1, 4'hF, 32'hABCD_0123);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_state", state, 2'd0);
    check("midrst_cyc", bus.s_cyc_o, '0);
    check("midrst_stb", bus.s_stb_o, '0);
    check("midrst_stall", bus.m_stall_o, 1'b0);
    check("midrst_dat", bus.m_dat_o, '0);
    check("midrst_sadr", bus.s_adr_o, '0);
    check("midrst_sdat", bus.s_dat_o, '0);
    model_dat = '0;
    bus.m_cyc_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    xact(32'h2000_0040, 1'b0, 4'hF, 32'h0, 0, 0, 0, 32'h1357_9BDF);

`ifdef RV32I_WB_DEC_TIMEOUT_EN
    xact(32'h0000_0100, 1'b0, 4'hF, 32'h0, 0, 0, 3, 32'h0);
    check("timeout_set", timeout, 1'b1);
    xact(32'h1000_0000, 1'b0, 4'hF, 32'h0, 0, 0, 0, 32'h2468_ACE0);
    check("timeout_sticky", timeout, 1'b1);
`endif

    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    repeat (3) @(negedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
